regex_stream_ctx: RTL

Parametrised per-stream context manager for one generated regex DFA in the packet-inspection core. It keeps DFA state across packets for up to 2^SID_W interleaved streams and registers every DFA input and output for timing. It keeps both a global and a per-stream saturating match count, and tracks stream validity internally, so no external new-stream flag is needed. It sits between the packet parser and one `*_verilog` DFA instance.

---
 rtl/regex_stream_ctx_pkg.sv | 22 ++
 rtl/regex_stream_ctx_if.sv | 34 +++
 rtl/regex_stream_ctx_ram.sv | 23 ++
 rtl/regex_stream_ctx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/regex_stream_ctx_pkg.sv
// Shared defaults, commit pipeline depth and saturating arithmetic for the
// regex stream context manager.
`timescale 1ns/1ps
package regex_ctx_pkg;

    localparam int STATE_W_DEF = 11;
    localparam int SID_W_DEF   = 6;
    localparam int CNT_W_DEF   = 16;
    localparam int PIPE_LAT    = 3;

    // Width must stay below 32 so the all-ones ceiling fits the 32-bit carrier.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc,
                                            input int width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        if (inc && (value != max_val)) begin
            return value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/regex_stream_ctx_if.sv
// Packet-parser and DFA-side signals of the context manager, bundled so the
// parser/DFA environment and the context block share one declaration.
`timescale 1ns/1ps
interface regex_stream_ctx_if
    import regex_ctx_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int SID_W   = SID_W_DEF
);
    logic               load_state;
    logic [SID_W-1:0]   stream_id;
    logic               enable;
    logic [7:0]         char_in;
    logic               char_in_vld;
    logic               eop;
    logic [7:0]         dfa_char;
    logic               dfa_char_vld;
    logic [STATE_W-1:0] dfa_state_in;
    logic               dfa_state_in_vld;
    logic [STATE_W-1:0] dfa_state_out;
    logic               dfa_accept;

    modport slave (
        input  load_state, stream_id, enable, char_in, char_in_vld, eop,
               dfa_state_out, dfa_accept,
        output dfa_char, dfa_char_vld, dfa_state_in, dfa_state_in_vld
    );

    modport master (
        output load_state, stream_id, enable, char_in, char_in_vld, eop,
               dfa_state_out, dfa_accept,
        input  dfa_char, dfa_char_vld, dfa_state_in, dfa_state_in_vld
    );
endinterface

// File: rtl/regex_stream_ctx_ram.sv
// Simple dual-port RAM: one write port, one registered read port that
// returns the old contents when read and write hit the same address.
`timescale 1ns/1ps
module regex_ctx_ram #(
    parameter int W  = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/regex_stream_ctx.sv
// Per-stream DFA context manager: restores/saves DFA state per stream id,
// registers the DFA interface and keeps global and per-stream match counts.
`timescale 1ns/1ps
module regex_stream_ctx
    import regex_ctx_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int SID_W   = SID_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    regex_stream_ctx_if.slave   bus,
    input  logic                clear_all,
    input  logic [SID_W-1:0]    rd_sid,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    count,
    output logic                fired,
    output logic                protocol_err
);
    localparam int NUM_SID = 1 << SID_W;

    logic [PIPE_LAT-1:0] eop_pipe_reg;
    logic [SID_W-1:0]    sid_reg, pend_sid_reg, load_sid;
    logic                en_reg, pend_en_reg, pend_reg, load_en;
    logic                window, direct_load, load_go, commit, commit_wr, hit;
    logic                load_d1_reg, load_valid_reg, rd_valid_reg;
    logic [NUM_SID-1:0]  valid_reg;
    logic [STATE_W-1:0]  state_rd, state_r_reg;
    logic                accept_r_reg;
    logic [CNT_W-1:0]    cnt_rd, cnt_base_reg, count_reg, readback_rd;
    logic [CNT_W-1:0]    count_next, stream_cnt_next;
    logic                fired_reg, perr_reg;

    // A load arriving while a commit is in flight is parked and replayed once
    // the commit has written, so it observes the freshly saved context.
    always_comb begin
        window          = |eop_pipe_reg;
        direct_load     = bus.load_state && !window;
        load_go         = direct_load || (pend_reg && !window);
        load_sid        = direct_load ? bus.stream_id : pend_sid_reg;
        load_en         = direct_load ? bus.enable : pend_en_reg;
        commit          = eop_pipe_reg[PIPE_LAT-1] && !clear_all;
        commit_wr       = commit && en_reg;
        hit             = fired_reg | accept_r_reg;
        count_next      = CNT_W'(sat_inc(32'(count_reg), hit, CNT_W));
        stream_cnt_next = CNT_W'(sat_inc(32'(cnt_base_reg), hit, CNT_W));
    end

    regex_ctx_ram #(.W(STATE_W), .AW(SID_W)) u_state_ram (
        .clk(clk), .wr_en(commit_wr), .wr_addr(sid_reg), .wr_data(state_r_reg),
        .rd_addr(load_sid), .rd_data(state_rd)
    );

    regex_ctx_ram #(.W(CNT_W), .AW(SID_W)) u_cnt_ram (
        .clk(clk), .wr_en(commit_wr), .wr_addr(sid_reg), .wr_data(stream_cnt_next),
        .rd_addr(load_sid), .rd_data(cnt_rd)
    );

    // Second copy of the count RAM gives readback its own read port.
    regex_ctx_ram #(.W(CNT_W), .AW(SID_W)) u_readback_ram (
        .clk(clk), .wr_en(commit_wr), .wr_addr(sid_reg), .wr_data(stream_cnt_next),
        .rd_addr(rd_sid), .rd_data(readback_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eop_pipe_reg         <= '0;
            sid_reg              <= '0;
            en_reg               <= 1'b0;
            pend_reg             <= 1'b0;
            pend_sid_reg         <= '0;
            pend_en_reg          <= 1'b0;
            load_d1_reg          <= 1'b0;
            load_valid_reg       <= 1'b0;
            rd_valid_reg         <= 1'b0;
            valid_reg            <= '0;
            state_r_reg          <= '0;
            accept_r_reg         <= 1'b0;
            cnt_base_reg         <= '0;
            count_reg            <= '0;
            fired_reg            <= 1'b0;
            perr_reg             <= 1'b0;
            bus.dfa_char         <= '0;
            bus.dfa_char_vld     <= 1'b0;
            bus.dfa_state_in     <= '0;
            bus.dfa_state_in_vld <= 1'b0;
        end else begin
            eop_pipe_reg         <= {eop_pipe_reg[PIPE_LAT-2:0], bus.eop};
            bus.dfa_char         <= bus.char_in;
            bus.dfa_char_vld     <= bus.char_in_vld;
            state_r_reg          <= bus.dfa_state_out;
            accept_r_reg         <= bus.dfa_accept;
            load_d1_reg          <= load_go;
            load_valid_reg       <= valid_reg[load_sid];
            rd_valid_reg         <= valid_reg[rd_sid];
            bus.dfa_state_in_vld <= load_d1_reg;

            if (load_go) begin
                sid_reg <= load_sid;
                en_reg  <= load_en;
            end

            if (bus.load_state && window) begin
                pend_reg     <= 1'b1;
                pend_sid_reg <= bus.stream_id;
                pend_en_reg  <= bus.enable;
                perr_reg     <= 1'b1;
            end else if (!window) begin
                pend_reg <= 1'b0;
            end

            // RAM data for a load lands one cycle later; invalid streams start fresh.
            if (load_d1_reg) begin
                bus.dfa_state_in <= load_valid_reg ? state_rd : '0;
                cnt_base_reg     <= load_valid_reg ? cnt_rd : '0;
            end

            if (clear_all || load_go || (commit && !en_reg)) begin
                fired_reg <= 1'b0;
            end else if (accept_r_reg) begin
                fired_reg <= 1'b1;
            end

            if (clear_all) begin
                count_reg <= '0;
                valid_reg <= '0;
            end else if (commit_wr) begin
                count_reg          <= count_next;
                valid_reg[sid_reg] <= 1'b1;
            end
        end
    end

    assign rd_count     = rd_valid_reg ? readback_rd : '0;
    assign count        = count_reg;
    assign fired        = fired_reg;
    assign protocol_err = perr_reg;

endmodule
